// File: rtl/seg_scan_decoder_if.sv
// Scan-bus bundle between a multiplexed 7-segment driver and its readback decoder.
// The master drives the segment/anode lines; the slave reports the rebuilt digits.
interface seg_scan_decoder_if;
    logic [6:0] DISPLAY;
    logic [3:0] DIGIT;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic [3:0] dig3;
    logic [3:0] dig_valid;
    logic       frame_pulse;
    logic [6:0] value;
    logic       value_ok;
    logic       bad_seg;
    logic       stall;

    modport master (
        output DISPLAY, DIGIT,
        input  dig0, dig1, dig2, dig3, dig_valid, frame_pulse, value, value_ok, bad_seg, stall
    );

    modport slave (
        input  DISPLAY, DIGIT,
        output dig0, dig1, dig2, dig3, dig_valid, frame_pulse, value, value_ok, bad_seg, stall
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Readback monitor for a multiplexed 7-segment scan bus: debounces each lit digit,
// decodes it to a 4-bit code, rebuilds the two-digit value and flags bad patterns/stalls.
module seg_scan_decoder #(
    parameter int STABLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1048576
) (
    input logic            clk,
    input logic            rst,
    seg_scan_decoder_if.slave bus
);
    localparam int CNT_W  = $clog2(STABLE_CYC + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_WAIT, S_COUNT, S_LATCHED} state_t;

    state_t             state, state_nxt;
    logic [6:0]         seg_p0, s_seg, ref_seg, ref_seg_nxt;
    logic [3:0]         dig_p0, s_dig, ref_dig, ref_dig_nxt;
    logic [CNT_W-1:0]   stab_cnt, stab_cnt_nxt, cnt_inc;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [3:0]         frame_mask, slot_bit;
    logic [3:0]         dig_r [4];
    logic [3:0]         acc_code, new_d0, new_d1;
    logic [1:0]         acc_slot;
    logic               accept, mismatch, onehot;

    function automatic logic [3:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'b1000000: return 4'd0;
            7'b1111001: return 4'd1;
            7'b0100100: return 4'd2;
            7'b0110000: return 4'd3;
            7'b0011001: return 4'd4;
            7'b0010010: return 4'd5;
            7'b0000010: return 4'd6;
            7'b1111000: return 4'd7;
            7'b0000000: return 4'd8;
            7'b0010000: return 4'd9;
            7'b1011100: return 4'd10;
            7'b1100011: return 4'd11;
            7'b1111111: return 4'd15;
            default:    return 4'd14;
        endcase
    endfunction

    function automatic logic is_onehot_low(input logic [3:0] d);
        case (d)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] slot_index(input logic [3:0] d);
        case (d)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [6:0] to_value(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] sum;
        sum = {1'b0, tens, 3'b000} + {3'b000, tens, 1'b0} + {4'b0000, ones};
        return sum[6:0];
    endfunction

    // Stage p0/p1: two-flop synchronizer on the asynchronous scan lines
    always_ff @(posedge clk) begin
        if (!rst) begin
            seg_p0 <= '0;
            s_seg  <= '0;
            dig_p0 <= '0;
            s_dig  <= '0;
        end else begin
            seg_p0 <= bus.DISPLAY;
            s_seg  <= seg_p0;
            dig_p0 <= bus.DIGIT;
            s_dig  <= dig_p0;
        end
    end

    assign mismatch = (s_dig != ref_dig) || (s_seg != ref_seg);
    assign onehot   = is_onehot_low(s_dig);
    assign cnt_inc  = stab_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_WAIT;
            ref_dig  <= '0;
            ref_seg  <= '0;
            stab_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ref_dig  <= ref_dig_nxt;
            ref_seg  <= ref_seg_nxt;
            stab_cnt <= stab_cnt_nxt;
        end
    end

    // Any leave from COUNT/LATCHED re-evaluates the new sample as if entering WAIT
    always_comb begin
        state_nxt    = state;
        ref_dig_nxt  = ref_dig;
        ref_seg_nxt  = ref_seg;
        stab_cnt_nxt = stab_cnt;
        if ((state == S_WAIT) || (state == S_LATCHED && s_dig != ref_dig) ||
            (state == S_COUNT && mismatch)) begin
            ref_dig_nxt  = s_dig;
            ref_seg_nxt  = s_seg;
            stab_cnt_nxt = CNT_W'(1);
            state_nxt    = onehot ? S_COUNT : S_WAIT;
        end else if (state == S_COUNT) begin
            stab_cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_W'(STABLE_CYC))
                state_nxt = S_LATCHED;
        end
    end

    always_comb begin
        accept   = (state == S_COUNT) && !mismatch && (cnt_inc == CNT_W'(STABLE_CYC));
        acc_code = seg_decode(s_seg);
        acc_slot = slot_index(s_dig);
        slot_bit = 4'b0001 << acc_slot;
        new_d0   = (acc_slot == 2'd0) ? acc_code : dig_r[0];
        new_d1   = (acc_slot == 2'd1) ? acc_code : dig_r[1];
    end

    // Stage p2: registered capture, frame assembly and stall supervision
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) dig_r[i] <= '0;
            bus.dig_valid   <= '0;
            bus.frame_pulse <= 1'b0;
            bus.value       <= '0;
            bus.value_ok    <= 1'b0;
            bus.bad_seg     <= 1'b0;
            bus.stall       <= 1'b0;
            frame_mask      <= '0;
            idle_cnt        <= '0;
        end else begin
            bus.frame_pulse <= 1'b0;
            if (accept) begin
                dig_r[acc_slot]         <= acc_code;
                bus.dig_valid[acc_slot] <= 1'b1;
                if (acc_code == 4'd14) bus.bad_seg <= 1'b1;
                idle_cnt  <= '0;
                bus.stall <= 1'b0;
                if ((frame_mask | slot_bit) == 4'b1111) begin
                    bus.frame_pulse <= 1'b1;
                    frame_mask      <= '0;
                    if (new_d1 <= 4'd9 && new_d0 <= 4'd9) begin
                        bus.value    <= to_value(new_d1, new_d0);
                        bus.value_ok <= 1'b1;
                    end else begin
                        bus.value_ok <= 1'b0;
                    end
                end else begin
                    frame_mask <= frame_mask | slot_bit;
                end
            end else if (idle_cnt != IDLE_W'(TIMEOUT_CYC)) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
                if (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) begin
                    bus.stall     <= 1'b1;
                    bus.dig_valid <= '0;
                    bus.value_ok  <= 1'b0;
                    frame_mask    <= '0;
                end
            end
        end
    end

    assign bus.dig0 = dig_r[0];
    assign bus.dig1 = dig_r[1];
    assign bus.dig2 = dig_r[2];
    assign bus.dig3 = dig_r[3];
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans hand-built frames and checks decoded
// digits, frame pulses, value, bad-pattern, stall and reset behaviour.
module tb_seg_scan_decoder;
    localparam int STABLE_CYC  = 4;
    localparam int TIMEOUT_CYC = 64;

    localparam logic [3:0] SLOT0 = 4'b1110;
    localparam logic [3:0] SLOT1 = 4'b1101;
    localparam logic [3:0] SLOT2 = 4'b1011;
    localparam logic [3:0] SLOT3 = 4'b0111;
    localparam logic [3:0] NONE  = 4'b1111;
    localparam logic [3:0] TWO   = 4'b1100;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_UP    = 7'b1011100;
    localparam logic [6:0] SEG_DOWN  = 7'b1100011;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_BAD   = 7'b1010101;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   p0;

    always #5 clk = ~clk;

    seg_scan_decoder_if bus();

    seg_scan_decoder #(
        .STABLE_CYC (STABLE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always @(posedge clk) pulses <= pulses + int'(bus.frame_pulse);

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input logic [3:0] dig, input logic [6:0] seg, input int n);
        bus.DIGIT   = dig;
        bus.DISPLAY = seg;
        step(n);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        bus.DIGIT   = NONE;
        bus.DISPLAY = SEG_BLANK;
        rst = 1'b0;
        step(3);
        chk("rst_digs", 32'({bus.dig3, bus.dig2, bus.dig1, bus.dig0}), 0);
        chk("rst_valid", 32'(bus.dig_valid), 0);
        chk("rst_pulse", 32'(bus.frame_pulse), 0);
        chk("rst_value", 32'(bus.value), 0);
        chk("rst_flags", 32'({bus.value_ok, bus.bad_seg, bus.stall}), 0);
        rst = 1'b1;

        // too-short sample on slot 0, then a good one on slot 1
        show(SLOT0, SEG_1, 3);
        show(SLOT1, SEG_3, 20);
        chk("short_valid", 32'(bus.dig_valid), 2);
        chk("short_dig1", 32'(bus.dig1), 3);
        chk("short_dig0", 32'(bus.dig0), 0);

        // frame 7,4,up,up with exact accept latency on slot 3
        p0 = pulses;
        show(SLOT0, SEG_7, 20);
        show(SLOT1, SEG_4, 20);
        show(SLOT2, SEG_UP, 20);
        show(SLOT3, SEG_UP, 5);
        chk("pulse_early", 32'(bus.frame_pulse), 0);
        step(1);
        chk("pulse_on_time", 32'(bus.frame_pulse), 1);
        chk("f47_dig3", 32'(bus.dig3), 10);
        chk("f47_value", 32'(bus.value), 47);
        chk("f47_ok", 32'(bus.value_ok), 1);
        step(14);
        chk("f47_pulses", 32'(pulses - p0), 1);
        chk("f47_dig0", 32'(bus.dig0), 7);
        chk("f47_dig1", 32'(bus.dig1), 4);
        chk("f47_dig2", 32'(bus.dig2), 10);
        chk("f47_bad", 32'(bus.bad_seg), 0);
        chk("f47_valid", 32'(bus.dig_valid), 15);

        // two active anodes must never be accepted
        show(SLOT0, SEG_0, 10);
        p0 = pulses;
        show(TWO, SEG_9, 50);
        chk("two_pulses", 32'(pulses - p0), 0);
        chk("two_digs", 32'({bus.dig3, bus.dig2, bus.dig1, bus.dig0}), 32'h0000AA40);
        chk("two_stall", 32'(bus.stall), 0);

        // undecodable pattern on slot 2
        show(SLOT2, SEG_BAD, 20);
        chk("bad_dig2", 32'(bus.dig2), 14);
        chk("bad_flag", 32'(bus.bad_seg), 1);

        p0 = pulses;
        show(SLOT0, SEG_5, 20);
        show(SLOT1, SEG_2, 20);
        show(SLOT2, SEG_9, 20);
        show(SLOT3, SEG_0, 20);
        chk("f25_pulses", 32'(pulses - p0), 1);
        chk("f25_value", 32'(bus.value), 25);
        chk("f25_ok", 32'(bus.value_ok), 1);
        chk("f25_bad_sticky", 32'(bus.bad_seg), 1);
        chk("f25_dig2", 32'(bus.dig2), 9);

        // blank ones digit: value holds, value_ok drops
        p0 = pulses;
        show(SLOT0, SEG_BLANK, 20);
        show(SLOT1, SEG_9, 20);
        show(SLOT2, SEG_1, 20);
        show(SLOT3, SEG_1, 20);
        chk("blank_pulses", 32'(pulses - p0), 1);
        chk("blank_dig0", 32'(bus.dig0), 15);
        chk("blank_value", 32'(bus.value), 25);
        chk("blank_ok", 32'(bus.value_ok), 0);

        show(SLOT0, SEG_9, 20);
        show(SLOT1, SEG_9, 20);
        show(SLOT2, SEG_DOWN, 20);
        show(SLOT3, SEG_8, 20);
        chk("f99_value", 32'(bus.value), 99);
        chk("f99_ok", 32'(bus.value_ok), 1);
        chk("f99_dig2", 32'(bus.dig2), 11);

        // slot-3 accept landed 14 cycles ago, so stall is due 50 cycles into the freeze
        show(NONE, SEG_BLANK, 49);
        chk("stall_early", 32'(bus.stall), 0);
        step(1);
        chk("stall_set", 32'(bus.stall), 1);
        chk("stall_valid", 32'(bus.dig_valid), 0);
        chk("stall_value", 32'(bus.value), 99);
        chk("stall_ok", 32'(bus.value_ok), 0);
        chk("stall_dig0", 32'(bus.dig0), 9);
        step(20);
        chk("stall_held", 32'(bus.stall), 1);
        show(SLOT1, SEG_3, 20);
        chk("stall_clear", 32'(bus.stall), 0);
        chk("stall_clr_dig1", 32'(bus.dig1), 3);
        chk("stall_clr_valid", 32'(bus.dig_valid), 2);

        // reset while slot 2 is part-way through its stability count
        show(SLOT0, SEG_7, 20);
        show(SLOT2, SEG_1, 4);
        rst = 1'b0;
        step(1);
        chk("mid_rst_valid", 32'(bus.dig_valid), 0);
        chk("mid_rst_digs", 32'({bus.dig3, bus.dig2, bus.dig1, bus.dig0}), 0);
        chk("mid_rst_value", 32'(bus.value), 0);
        chk("mid_rst_flags", 32'({bus.value_ok, bus.bad_seg, bus.stall}), 0);
        rst = 1'b1;
        p0 = pulses;
        step(5);
        chk("post_rst_early", 32'(bus.dig_valid), 0);
        step(1);
        chk("post_rst_acc", 32'(bus.dig_valid), 4);
        chk("post_rst_dig2", 32'(bus.dig2), 1);
        step(14);
        show(SLOT3, SEG_0, 20);
        show(SLOT0, SEG_6, 20);
        chk("fresh_nopulse", 32'(pulses - p0), 0);
        chk("fresh_valid", 32'(bus.dig_valid), 13);
        show(SLOT1, SEG_8, 20);
        chk("fresh_pulse", 32'(pulses - p0), 1);
        chk("fresh_value", 32'(bus.value), 86);
        chk("fresh_ok", 32'(bus.value_ok), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 7-segment scan bus driven by four_bit_player (DISPLAY/DIGIT).
- Samples the scanned segment/anode lines and decodes each active digit back to its 4-bit code.
- Rebuilds the four digit registers and the two-digit decimal value, and flags bad patterns and scan stalls.
- Used as an on-board readback monitor and as the self-check element in display-path benches.

Parameters:
STABLE_CYC, 16, consecutive identical synchronized samples required to accept a digit (min 2)
TIMEOUT_CYC, 1048576, cycles without any accepted digit before stall is declared

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
DISPLAY  in  7  segments {g,f,e,d,c,b,a}, active-low
DIGIT  in  4  anodes, active-low; DIGIT[i]=0 selects slot i
dig0  out  4  decoded code, slot 0 (ones)
dig1  out  4  decoded code, slot 1 (tens)
dig2  out  4  decoded code, slot 2
dig3  out  4  decoded code, slot 3
dig_valid  out  4  bit i set once slot i captured since reset/stall
frame_pulse  out  1  one-cycle pulse when all four slots captured in current frame
value  out  7  dig1*10+dig0, updated on frame_pulse
value_ok  out  1  value holds a legal 0..99 result
bad_seg  out  1  sticky: an accepted sample had an undecodable pattern
stall  out  1  no digit accepted for TIMEOUT_CYC cycles

Behaviour:
- Reset (rst==0 at posedge clk): all outputs 0; FSM to WAIT; synchronizers, counters, and frame mask cleared.
- Two-flop synchronizer on DISPLAY and DIGIT. All logic below uses synchronized values (s_seg, s_dig); input-to-decision latency is 2 cycles.
- Decode table, s_seg to code:
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
  - 1011100=10 (up arrow), 1100011=11 (down arrow), 1111111=15 (blank).
  - Any other pattern = 14 and is illegal.
- FSM:
  - WAIT: if s_dig is one-hot-low (exactly one 0), load stab_cnt=1 and latch ref_dig/ref_seg, then go to COUNT. Otherwise stay.
  - COUNT:
    - If s_dig!=ref_dig or s_seg!=ref_seg: reload ref with current values, stab_cnt=1, and stay in COUNT if the new s_dig is one-hot, else go to WAIT.
    - Otherwise stab_cnt++. When stab_cnt reaches STABLE_CYC, accept the sample and go to LATCHED.
  - LATCHED: stay while s_dig==ref_dig. Any change goes to WAIT with the same evaluation applied that cycle; the same anode re-entering is captured again.
- Accept, registered, visible the cycle after the accept decision:
  - dig<i> = code; dig_valid[i]=1; frame_mask[i]=1.
  - If code==14, set bad_seg. It clears only on reset.
  - idle_cnt=0; stall=0.
- Frame:
  - When an accept makes frame_mask==4'b1111, pulse frame_pulse for 1 cycle in the same cycle the dig outputs update, then clear frame_mask.
  - value/value_ok update on that pulse. If dig1<=9 and dig0<=9: value=dig1*10+dig0 and value_ok=1. Otherwise value holds and value_ok=0.
  - Re-capturing an already-masked slot before the frame completes overwrites dig<i> and does not pulse.
- Stall:
  - idle_cnt increments each cycle with no accept and saturates at TIMEOUT_CYC.
  - On reaching TIMEOUT_CYC: stall=1, dig_valid=0, frame_mask=0, value_ok=0. dig<i> and value hold.
  - The first subsequent accept clears stall.
- Zero or multiple active anodes are never accepted.
- A reset mid-COUNT discards the partial sample.
- Width rules: value computed as {dig1,3'b0}+{dig1,1'b0}+dig0, truncated to 7 bits; only used when legal.

Test Plan (sim with STABLE_CYC=4, TIMEOUT_CYC=64):
- Scan slots 0..3 with seg codes 7,4,10,10, each held 20 cycles -> dig0=7, dig1=4, dig2=dig3=10; one frame_pulse after the slot-3 accept; value=47, value_ok=1; bad_seg=0.
- Slot 0 shows pattern 1 for only 3 cycles, then switches to slot 1 -> no accept on slot 0; dig_valid[0] stays 0.
- DIGIT=4'b1100 (two active) held 50 cycles -> no accept; FSM remains WAIT.
- Slot 2 shows 1010101 for 20 cycles -> dig2=14, bad_seg=1 and sticky across later legal frames until rst=0.
- Complete a frame, then freeze DIGIT=4'b1111 for 70 cycles -> stall=1 at idle 64, dig_valid=0, value holds, value_ok=0; the next legal accept clears stall.
- Assert rst=0 for one cycle mid-COUNT during a frame -> all outputs 0 next cycle; a full fresh frame is needed before frame_pulse.
